// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;
    localparam logic [31:0] PC_STEP       = 32'd4;

    typedef struct packed {
        logic [31:0] pc_value;
        logic [31:0] instruction_value;
        logic        pc_r;
        logic        instr_done;
    } fe_to_de_s;

    typedef enum logic {
        FETCH  = 1'b0,
        HALTED = 1'b1
    } fe_state_e;

    function automatic fe_to_de_s make_bubble(
        input logic [31:0] pc,
        input logic [31:0] nop
    );
        fe_to_de_s b;
        b.pc_value          = pc;
        b.instruction_value = nop;
        b.pc_r              = 1'b1;
        b.instr_done        = 1'b0;
        return b;
    endfunction

    function automatic fe_to_de_s make_instr(
        input logic [31:0] pc,
        input logic [31:0] instr
    );
        fe_to_de_s r;
        r.pc_value          = pc;
        r.instruction_value = instr;
        r.pc_r              = 1'b0;
        r.instr_done        = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry {pc, instr} holding buffer for fetch responses
// that arrive while decode is stalled.
module fetch_skid (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        load_i,
    input  logic        drain_i,
    input  logic        flush_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] instr_i,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o
);

    logic        valid_q, valid_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            pc_d    = pc_i;
            instr_d = instr_i;
        end else if (drain_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign instr_o = instr_q;

endmodule

// File: rtl/fetch.sv
// Instruction-fetch stage: PC, imem req/ack, redirect squash,
// halt handling and a one-deep output register with skid.
module fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        pc_r,
    input  logic [31:0] pc_target,
    input  logic        halt,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output fe_to_de_s   fe_to_de,
    output logic [31:0] fetch_count
);

    fe_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        kill_q, kill_d;
    logic [31:0] kill_addr_q, kill_addr_d;
    logic        halt_pend_q, halt_pend_d;
    fe_to_de_s   out_q, out_d;
    logic [31:0] cnt_q, cnt_d;

    logic        skid_valid;
    logic [31:0] skid_pc;
    logic [31:0] skid_instr;
    logic        skid_load;
    logic        skid_drain;
    logic        skid_flush;

    logic        halting;
    logic        redir;
    logic        accept;

    assign halting   = halt || halt_pend_q;
    assign redir     = pc_r && !halting;
    assign imem_req  = (state_q == FETCH) && !skid_valid;
    // A squashed request keeps its original address until its ack.
    assign imem_addr = kill_q ? kill_addr_q : pc_q;
    assign accept    = imem_ack && imem_req && !kill_q
                       && !pc_r && !halting;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        kill_d      = kill_q;
        kill_addr_d = kill_addr_q;
        halt_pend_d = halt_pend_q | halt;
        out_d       = out_q;
        cnt_d       = cnt_q;
        skid_load   = 1'b0;
        skid_drain  = 1'b0;
        skid_flush  = 1'b0;

        unique case (state_q)
            FETCH: begin
                if (halting && (!imem_req || imem_ack)) begin
                    state_d = HALTED;
                end
            end
            HALTED:  state_d = HALTED;
            default: state_d = FETCH;
        endcase

        if (imem_req && imem_ack && kill_q) begin
            kill_d = 1'b0;
        end

        if (redir) begin
            pc_d       = pc_target;
            skid_flush = 1'b1;
            if (imem_req && !imem_ack) begin
                kill_d = 1'b1;
                if (!kill_q) begin
                    kill_addr_d = pc_q;
                end
            end
        end else if (accept) begin
            pc_d = pc_q + PC_STEP;
        end

        // Anything fetched past a halt is beyond the last instruction.
        if (halting) begin
            out_d      = make_bubble(pc_q, NOP_INSTR);
            skid_flush = 1'b1;
        end else if (pc_r) begin
            out_d = make_bubble(pc_q, NOP_INSTR);
        end else if (en && skid_valid) begin
            out_d      = make_instr(skid_pc, skid_instr);
            skid_drain = 1'b1;
            cnt_d      = cnt_q + 32'd1;
        end else if (en && accept) begin
            out_d = make_instr(pc_q, imem_rdata);
            cnt_d = cnt_q + 32'd1;
        end else if (en) begin
            out_d = make_bubble(pc_q, NOP_INSTR);
        end else if (accept) begin
            skid_load = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            kill_q      <= 1'b0;
            kill_addr_q <= '0;
            halt_pend_q <= 1'b0;
            out_q       <= make_bubble(RESET_PC, NOP_INSTR);
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            kill_q      <= kill_d;
            kill_addr_q <= kill_addr_d;
            halt_pend_q <= halt_pend_d;
            out_q       <= out_d;
            cnt_q       <= cnt_d;
        end
    end

    fetch_skid u_skid (
        .clk_i   (clk),
        .rst_ni  (reset),
        .load_i  (skid_load),
        .drain_i (skid_drain),
        .flush_i (skid_flush),
        .pc_i    (pc_q),
        .instr_i (imem_rdata),
        .valid_o (skid_valid),
        .pc_o    (skid_pc),
        .instr_o (skid_instr)
    );

    assign fe_to_de    = out_q;
    assign fetch_count = cnt_q;

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for fetch: variable-latency memory model
// plus a queue of expected delivered instructions.
module tb_fetch;
    import fetch_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b1;
    logic        pc_r = 1'b0;
    logic [31:0] pc_target = '0;
    logic        halt = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    fe_to_de_s   fe_to_de;
    logic [31:0] fetch_count;

    int          lat = 0;
    int          wcnt;
    int          n_chk = 0;
    int          n_pass = 0;
    logic [31:0] last_cnt = '0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    fetch #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .pc_r       (pc_r),
        .pc_target  (pc_target),
        .halt       (halt),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .fe_to_de   (fe_to_de),
        .fetch_count(fetch_count)
    );

    // Memory: ack once the request has waited lat cycles.
    always @(posedge clk or negedge reset) begin
        if (!reset) wcnt <= 0;
        else if (imem_req && !imem_ack) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end
    assign imem_ack   = imem_req && (wcnt >= lat);
    assign imem_rdata = imem_addr | 32'h13;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        logic [31:0] e;
        @(posedge clk);
        #1;
        if (reset && fetch_count != last_cnt) begin
            last_cnt = fetch_count;
            chk("sb_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb_pc", fe_to_de.pc_value, e);
                chk("sb_ins", fe_to_de.instruction_value, e | 32'h13);
                chk("sb_done", 32'(fe_to_de.instr_done), 32'd1);
            end
        end
    endtask

    task automatic do_reset();
        en = 1'b1; pc_r = 1'b0; halt = 1'b0; lat = 0;
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_pc", fe_to_de.pc_value, RST_PC);
        chk("rst_bub", 32'(fe_to_de.pc_r), 32'd1);
        chk("rst_done", 32'(fe_to_de.instr_done), 32'd0);
        chk("rst_ins", fe_to_de.instruction_value, NOP);
        chk("rst_cnt", fetch_count, 32'd0);
        chk("sb_left", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        last_cnt = '0;
        reset = 1'b1;
        #1;
        chk("rst_req", 32'(imem_req), 32'd1);
        chk("rst_addr", imem_addr, RST_PC);
    endtask

    initial begin
        #2;
        // Zero-wait streaming
        do_reset();
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        repeat (3) tick();
        chk("t1_cnt", fetch_count, 32'd3);
        chk("t1_done", 32'(fe_to_de.instr_done), 32'd1);

        // Three-cycle memory latency
        do_reset();
        lat = 3;
        exp_q.push_back(32'h0);
        for (int i = 0; i < 3; i++) begin
            chk("t2_req", 32'(imem_req), 32'd1);
            chk("t2_addr", imem_addr, 32'h0);
            chk("t2_bub", 32'(fe_to_de.pc_r), 32'd1);
            tick();
        end
        chk("t2_bub3", 32'(fe_to_de.pc_r), 32'd1);
        tick();
        chk("t2_cnt", fetch_count, 32'd1);

        // Decode stall while the 0x8 response lands
        do_reset();
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        exp_q.push_back(32'hC);
        tick(); tick();
        en = 1'b0;
        tick();
        chk("t3_hold", fe_to_de.pc_value, 32'h4);
        chk("t3_req", 32'(imem_req), 32'd0);
        tick();
        chk("t3_hold2", fe_to_de.pc_value, 32'h4);
        chk("t3_req2", 32'(imem_req), 32'd0);
        chk("t3_cnt_hold", fetch_count, 32'd2);
        en = 1'b1;
        tick();
        chk("t3_drain", fe_to_de.pc_value, 32'h8);
        tick();
        chk("t3_next", fe_to_de.pc_value, 32'hC);
        chk("t3_cnt", fetch_count, 32'd4);

        // Redirect while the 0x10 request waits
        do_reset();
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        exp_q.push_back(32'hC);
        repeat (4) tick();
        chk("t4_addr10", imem_addr, 32'h10);
        lat = 2; pc_r = 1'b1; pc_target = 32'h100;
        tick();
        pc_r = 1'b0;
        chk("t4_keep_addr", imem_addr, 32'h10);
        chk("t4_keep_req", 32'(imem_req), 32'd1);
        chk("t4_bub", 32'(fe_to_de.pc_r), 32'd1);
        tick();
        chk("t4_keep_addr2", imem_addr, 32'h10);
        tick();
        chk("t4_new_addr", imem_addr, 32'h100);
        chk("t4_bub2", 32'(fe_to_de.pc_r), 32'd1);
        chk("t4_cnt_squash", fetch_count, 32'd4);
        lat = 0;
        exp_q.push_back(32'h100);
        for (int i = 0; i < 10 && fetch_count != 32'd5; i++) tick();
        chk("t4_cnt", fetch_count, 32'd5);

        // Redirect with same-cycle ack during a stall
        do_reset();
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        tick(); tick();
        en = 1'b0; pc_r = 1'b1; pc_target = 32'h100;
        tick();
        pc_r = 1'b0;
        chk("t5_bub", 32'(fe_to_de.pc_r), 32'd1);
        chk("t5_done", 32'(fe_to_de.instr_done), 32'd0);
        chk("t5_bpc", fe_to_de.pc_value, 32'h8);
        chk("t5_skid_empty", 32'(imem_req), 32'd1);
        chk("t5_addr", imem_addr, 32'h100);
        en = 1'b1;
        exp_q.push_back(32'h100);
        tick();
        chk("t5_cnt", fetch_count, 32'd3);

        // Halt with a request outstanding
        do_reset();
        exp_q.push_back(32'h0);
        tick();
        lat = 3; halt = 1'b1;
        chk("t6_req_pre", 32'(imem_req), 32'd1);
        tick();
        halt = 1'b0;
        chk("t6_req_wait", 32'(imem_req), 32'd1);
        chk("t6_addr_wait", imem_addr, 32'h4);
        for (int i = 0; i < 10 && imem_req; i++) tick();
        chk("t6_req_off", 32'(imem_req), 32'd0);
        pc_r = 1'b1; pc_target = 32'h200;
        tick();
        pc_r = 1'b0;
        repeat (4) begin
            tick();
            chk("t6_req_dead", 32'(imem_req), 32'd0);
            chk("t6_bub", 32'(fe_to_de.pc_r), 32'd1);
        end
        chk("t6_cnt", fetch_count, 32'd1);
        do_reset();
        exp_q.push_back(32'h0);
        tick();
        chk("t6_restart", fetch_count, 32'd1);
        chk("sb_final", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
